// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic result path: drain FSM states and the
// flat-matrix element addressing used by both the RTL and its bench.
package systolic_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Bit offset of element (row, col) inside a flat size x size matrix.
  function automatic int elem_offset(input int row, input int col,
                                     input int size, input int o_bits);
    return (row * size + col) * o_bits;
  endfunction

  // Active dimension N = 1 << size_log2, clamped to the physical array size.
  function automatic int active_n(input int size_log2, input int size);
    if (size_log2 >= 30) return size;
    return ((1 << size_log2) > size) ? size : (1 << size_log2);
  endfunction

endpackage

// File: rtl/systolic_result_drain_if.sv
// Capture + row-stream bundle between the systolic array, the result drain
// and the downstream consumer. o_checksum exists only with RESULT_DRAIN_CHECKSUM_EN.
interface systolic_result_drain_if #(
  parameter int SIZE     = 4,
  parameter int O_BITS   = 16,
  parameter int IDX_BITS = (SIZE > 1) ? $clog2(SIZE) : 1
);
  localparam int SL_BITS = $clog2(SIZE) + 1;

  logic                        i_done;
  logic [SL_BITS-1:0]          i_size_log2;
  logic [SIZE*SIZE*O_BITS-1:0] i_c_full;
  logic                        i_ready;
  logic                        o_valid;
  logic [SIZE*O_BITS-1:0]      o_row_data;
  logic [IDX_BITS-1:0]         o_row_idx;
  logic                        o_last;
  logic                        o_busy;
  logic                        o_overrun;
`ifdef RESULT_DRAIN_CHECKSUM_EN
  logic [O_BITS-1:0]           o_checksum;
`endif

  // The drain is the master of the row stream.
  modport master (
    input  i_done, i_size_log2, i_c_full, i_ready,
`ifdef RESULT_DRAIN_CHECKSUM_EN
    output o_checksum,
`endif
    output o_valid, o_row_data, o_row_idx, o_last, o_busy, o_overrun
  );

  modport slave (
    output i_done, i_size_log2, i_c_full, i_ready,
`ifdef RESULT_DRAIN_CHECKSUM_EN
    input  o_checksum,
`endif
    input  o_valid, o_row_data, o_row_idx, o_last, o_busy, o_overrun
  );

endinterface

// File: rtl/systolic_result_drain.sv
// Captures the finished result matrix on i_done and streams it out one row per
// valid/ready beat. Optional running XOR checksum under RESULT_DRAIN_CHECKSUM_EN.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int SIZE     = 4,
  parameter int O_BITS   = 16,
  parameter int IDX_BITS = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input logic                     i_clock,
  input logic                     i_reset,
  systolic_result_drain_if.master bus
);

  localparam int N_BITS   = $clog2(SIZE) + 1;
  localparam int MAT_BITS = SIZE * SIZE * O_BITS;
  localparam int ROW_BITS = SIZE * O_BITS;

  state_e              state_q, state_d;
  logic [MAT_BITS-1:0] cap_q;
  logic [N_BITS-1:0]   n_q, n_d;
  logic [IDX_BITS-1:0] row_q, row_d;
  logic                overrun_q;

  logic                load;
  logic                overrun_set;
  logic                valid;
  logic                xfer;
  logic                last_row;
  logic [ROW_BITS-1:0] row_data;

  assign valid    = (state_q == ST_DRAIN);
  assign xfer     = valid & bus.i_ready;
  assign n_d      = N_BITS'(active_n(int'(bus.i_size_log2), SIZE));
  assign last_row = (N_BITS'(row_q) == (n_q - N_BITS'(1)));

  // Row select: indexed slice of the capture register, columns >= N masked off.
  always_comb begin
    row_data = '0;
    if (valid) begin
      for (int c = 0; c < SIZE; c++) begin
        if (c < int'(n_q)) begin
          row_data[c*O_BITS +: O_BITS] =
            cap_q[elem_offset(int'(row_q), c, SIZE, O_BITS) +: O_BITS];
        end
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    load        = 1'b0;
    overrun_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_done) begin
          load    = 1'b1;
          state_d = ST_DRAIN;
          row_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (xfer && last_row) begin
          // A capture coinciding with the final transfer restarts with no bubble.
          row_d = '0;
          if (bus.i_done) load = 1'b1;
          else            state_d = ST_IDLE;
        end else begin
          if (xfer)       row_d = row_q + 1'b1;
          if (bus.i_done) overrun_set = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: the capture register is wide but still reset, so pending rows and
  // stale data are gone as soon as reset asserts.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cap_q     <= '0;
      n_q       <= '0;
      row_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      row_q <= row_d;
      if (load) begin
        cap_q <= bus.i_c_full;
        n_q   <= n_d;
      end
      if (overrun_set) overrun_q <= 1'b1;
    end
  end

  assign bus.o_valid    = valid;
  assign bus.o_row_data = row_data;
  assign bus.o_row_idx  = row_q;
  assign bus.o_last     = valid & last_row;
  assign bus.o_busy     = valid;
  assign bus.o_overrun  = overrun_q;

`ifdef RESULT_DRAIN_CHECKSUM_EN
  logic [O_BITS-1:0] csum_q;
  logic [O_BITS-1:0] row_xor;

  always_comb begin
    row_xor = '0;
    for (int c = 0; c < SIZE; c++) row_xor ^= row_data[c*O_BITS +: O_BITS];
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)   csum_q <= '0;
    else if (load) csum_q <= '0;
    else if (xfer) csum_q <= csum_q ^ row_xor;
  end

  // On the last beat the final row is folded in early so the full sum is visible.
  assign bus.o_checksum = (valid & last_row) ? (csum_q ^ row_xor) : csum_q;
`endif

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Output-side companion to systolic_processorVCounter: captures the flat result matrix o_c_full once a multiplication completes, then streams it out one row per beat over a valid/ready interface.
- Sits between the systolic array and the downstream consumer (result FIFO / comparator). The array never has to hold its accumulators while the consumer stalls.

Parameters:
- SIZE, 4, physical array dimension (rows = cols)
- O_BITS, 16, width of one result element
- IDX_BITS, $clog2(SIZE) (minimum 1), width of the row index output

Ports:
- i_clock  in  1  single clock; all state changes on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_done  in  1  one-cycle pulse: i_c_full is final and stable this cycle
- i_size_log2  in  $clog2(SIZE)+1  active dimension N = 1<<i_size_log2, sampled with i_done
- i_c_full  in  SIZE*SIZE*O_BITS  result matrix; element (r,c) at bits [(r*SIZE+c)*O_BITS +: O_BITS]
- i_ready  in  1  consumer can accept a beat
- o_valid  out  1  o_row_data / o_row_idx hold a valid row
- o_row_data  out  SIZE*O_BITS  column c at bits [c*O_BITS +: O_BITS]; columns >= N forced to 0
- o_row_idx  out  IDX_BITS  row number of the current beat
- o_last  out  1  high with the beat carrying row N-1
- o_busy  out  1  high while a captured matrix is not fully drained
- o_overrun  out  1  sticky: i_done arrived while busy and was dropped

Behaviour:
- Reset (async, immediate): state IDLE; o_valid=0, o_row_data=0, o_row_idx=0, o_last=0, o_busy=0, o_overrun=0; capture register cleared.
- N computation: if (1<<i_size_log2) > SIZE, clamp N=SIZE. i_size_log2=0 gives N=1. N is latched at capture and held for the whole drain.
- IDLE: on i_done, register all of i_c_full plus N, and go to DRAIN with row=0.
  - o_valid rises the next cycle, so latency from i_done to first beat is 1 cycle.
- DRAIN:
  - o_valid=1; o_row_data = captured row `row`, with columns >= N zeroed; o_row_idx=row; o_last=(row==N-1).
  - A transfer occurs when o_valid & i_ready. On transfer, row increments.
  - On transfer of row N-1, return to IDLE; o_valid falls the next cycle unless a new capture happens.
  - While o_valid & !i_ready, all outputs hold stable. o_valid never drops without a transfer.
- o_busy = (state==DRAIN).
- Simultaneous events:
  - i_done in the same cycle as the last-row transfer is accepted: new capture, stay in DRAIN at row 0, no bubble.
  - i_done at any other DRAIN cycle is ignored. It sets o_overrun, and the capture register is untouched.
- o_overrun clears only on reset.
- Reset mid-drain: pending rows are discarded. There is no partial output after reset deassertion.
- No arithmetic on data; values pass bit-exact, unsigned/signed agnostic.

Optional Feature:
- Macro: RESULT_DRAIN_CHECKSUM_EN.
- Defined:
  - Adds output o_checksum [O_BITS-1:0].
  - A running XOR of every element of every transferred row (zeroed columns contribute 0), reset to 0 at each capture.
  - o_checksum equals the XOR of all N*N active elements during the o_last beat and holds until the next capture.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package systolic_pkg:
  - state encoding localparams ST_IDLE=1'b0, ST_DRAIN=1'b1
  - element-slice helper function (row, col, SIZE, O_BITS → bit offset), also used by the testbench matching logic
- No sub-module. The row select is an indexed part-select of the capture register plus a column mask, and stays inline (about 150–200 lines total).

Test Plan (SIZE=4, O_BITS=16):
- Basic drain, always ready:
  - Stimulus: i_c_full element k = k+1, i_size_log2=2, i_done pulse, i_ready=1.
  - Response: rows 0..3 on 4 consecutive cycles starting 1 cycle after i_done; row 2 data = {12,11,10,9}; o_last on row 3 only; o_busy falls after.
- Backpressure:
  - Stimulus: same matrix, i_ready toggled 1,0,0,1,0,1,1.
  - Response: each row is held stable while stalled, with no skipped or duplicated rows; exactly 4 transfers; o_row_idx 0,1,2,3.
- Reduced size:
  - Stimulus: i_size_log2=1.
  - Response: 2 beats; row 0 = {0,0,2,1}, row 1 = {0,0,6,5}; o_last on row 1.
  - Also: i_size_log2=3 clamps to N=4.
- Overrun and back-to-back:
  - Stimulus: i_done at the second beat, then i_done coincident with the last transfer.
  - Response: the first extra pulse sets o_overrun=1 and data is unchanged; the coincident pulse starts a new drain at row 0 with no idle cycle.
- Async reset mid-drain:
  - Stimulus: assert i_reset between clock edges during row 1.
  - Response: o_valid, o_busy and o_row_idx go to 0 immediately; no beats after release until the next i_done.
- Checksum (macro defined):
  - Stimulus: element k = k+1, N=4.
  - Response: o_checksum = XOR(1..16) = 16 on the o_last beat.
